// File: rtl/insn_sequencer.sv
// insn_sequencer: instruction sequencer sitting between the instruction ROM and
// the compute engines. It decodes one 32-bit instruction per S_DEC cycle, latches
// layer/dimension configuration, dispatches LIF/LW/SOF phases to engine[layer_type]
// through a start/done handshake, runs nested hardware loops and traps illegal ops.
// Optional feature: define INSN_SEQ_PERF_EN to get a saturating busy-cycle counter
// on perf_cyc_o. Without it perf_cyc_o is tied to zero.
// Opcodes are taken from the OP_* macros below and may be overridden before this file.

`ifndef OP_CFGL
`define OP_CFGL 5'h01
`endif
`ifndef OP_CFGD
`define OP_CFGD 5'h02
`endif
`ifndef OP_LIF
`define OP_LIF  5'h03
`endif
`ifndef OP_LW
`define OP_LW   5'h04
`endif
`ifndef OP_SOF
`define OP_SOF  5'h05
`endif
`ifndef OP_EOC
`define OP_EOC  5'h06
`endif
`ifndef OP_LOOP
`define OP_LOOP 5'h07
`endif
`ifndef OP_ENDL
`define OP_ENDL 5'h08
`endif

module insn_sequencer #(
    parameter int IADDR_W    = 13,
    parameter int ADDR_W     = 27,
    parameter int DIM_W      = 11,
    parameter int NUM_ENG    = 2,
    parameter int LOOP_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               run_i,
    output logic [IADDR_W-1:0] iaddr_o,
    input  logic [31:0]        idata_i,
    output logic [4:0]         layer_type_o,
    output logic [4:0]         act_type_o,
    output logic               has_bias_o,
    output logic [DIM_W-1:0]   cin_o,
    output logic [DIM_W-1:0]   cout_o,
    output logic [ADDR_W-1:0]  base_addr_o,
    output logic [1:0]         phase_o,
    output logic [NUM_ENG-1:0] eng_rst_o,
    output logic [NUM_ENG-1:0] eng_start_o,
    input  logic [NUM_ENG-1:0] eng_done_i,
    output logic               busy_o,
    output logic               halted_o,
    output logic               err_o,
    output logic [31:0]        perf_cyc_o
);

    localparam int SP_W  = $clog2(LOOP_DEPTH + 1);
    localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_DEC   = 3'd0,
        S_CFG   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [IADDR_W-1:0]  iaddr_q, iaddr_d;
    logic [4:0]          layerType_q, layerType_d;
    logic [4:0]          actType_q, actType_d;
    logic                hasBias_q, hasBias_d;
    logic [DIM_W-1:0]    cin_q, cin_d;
    logic [DIM_W-1:0]    cout_q, cout_d;
    logic [ADDR_W-1:0]   baseAddr_q, baseAddr_d;
    logic [1:0]          phase_q, phase_d;
    logic                cfgIsD_q, cfgIsD_d;
    logic                err_q, err_d;
    logic                halted_q, halted_d;

    // Loop stack: return address and remaining iteration count per entry.
    logic [IADDR_W-1:0]  loopStart_q [LOOP_DEPTH];
    logic [CNT_W-1:0]    loopRem_q   [LOOP_DEPTH];
    logic [SP_W-1:0]     loopSp_q;
    logic                pushEn, popEn, decEn;

    logic [4:0]          opcode;
    logic [CNT_W-1:0]    loopN;
    logic [IDX_W-1:0]    pushIdx, topIdx;
    logic                stackFull, stackEmpty;
    logic                engValid, engDone;
    logic [NUM_ENG-1:0]  engSel;

    assign opcode     = idata_i[31:27];
    assign loopN      = (idata_i[CNT_W-1:0] == '0) ? CNT_W'(1) : idata_i[CNT_W-1:0];
    assign stackFull  = (loopSp_q == SP_W'(LOOP_DEPTH));
    assign stackEmpty = (loopSp_q == '0);
    assign pushIdx    = IDX_W'(loopSp_q);
    assign topIdx     = IDX_W'(loopSp_q - SP_W'(1));
    assign engValid   = (int'(layerType_q) < NUM_ENG);
    assign engSel     = NUM_ENG'(1) << layerType_q;
    assign engDone    = |(eng_done_i & engSel);

    // Decode, handshake sequencing and error trapping; an error freezes iaddr on the offending instruction.
    always_comb begin
        state_d     = state_q;
        iaddr_d     = iaddr_q;
        layerType_d = layerType_q;
        actType_d   = actType_q;
        hasBias_d   = hasBias_q;
        cin_d       = cin_q;
        cout_d      = cout_q;
        baseAddr_d  = baseAddr_q;
        phase_d     = phase_q;
        cfgIsD_d    = cfgIsD_q;
        err_d       = err_q;
        halted_d    = halted_q;
        pushEn      = 1'b0;
        popEn       = 1'b0;
        decEn       = 1'b0;

        case (state_q)
            S_DEC: begin
                if (run_i) begin
                    iaddr_d = iaddr_q + IADDR_W'(1);
                    case (opcode)
                        `OP_CFGL: begin
                            layerType_d = idata_i[20:16];
                            actType_d   = idata_i[9:5];
                            hasBias_d   = idata_i[0];
                            cfgIsD_d    = 1'b0;
                            state_d     = S_CFG;
                        end
                        `OP_CFGD: begin
                            if (engValid) begin
                                cin_d    = idata_i[16+DIM_W-1:16];
                                cout_d   = idata_i[5+DIM_W-1:5];
                                cfgIsD_d = 1'b1;
                                state_d  = S_CFG;
                            end else begin
                                iaddr_d  = iaddr_q;
                                err_d    = 1'b1;
                                halted_d = 1'b1;
                                state_d  = S_HALT;
                            end
                        end
                        `OP_LIF, `OP_LW, `OP_SOF: begin
                            if (engValid) begin
                                baseAddr_d = idata_i[ADDR_W-1:0];
                                phase_d    = (opcode == `OP_LIF) ? 2'd0 :
                                             (opcode == `OP_LW)  ? 2'd1 : 2'd2;
                                state_d    = S_START;
                            end else begin
                                iaddr_d  = iaddr_q;
                                err_d    = 1'b1;
                                halted_d = 1'b1;
                                state_d  = S_HALT;
                            end
                        end
                        `OP_LOOP: begin
                            if (stackFull) begin
                                iaddr_d  = iaddr_q;
                                err_d    = 1'b1;
                                halted_d = 1'b1;
                                state_d  = S_HALT;
                            end else begin
                                pushEn = 1'b1;
                            end
                        end
                        `OP_ENDL: begin
                            if (stackEmpty) begin
                                iaddr_d  = iaddr_q;
                                err_d    = 1'b1;
                                halted_d = 1'b1;
                                state_d  = S_HALT;
                            end else if (loopRem_q[topIdx] > CNT_W'(1)) begin
                                decEn   = 1'b1;
                                iaddr_d = loopStart_q[topIdx];
                            end else begin
                                popEn = 1'b1;
                            end
                        end
                        `OP_EOC: begin
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end
                        default: begin
                            iaddr_d  = iaddr_q;
                            err_d    = 1'b1;
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end
                    endcase
                end
            end
            S_CFG:   state_d = S_DEC;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (engDone) begin
                    state_d = S_DEC;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_DEC;
        endcase
    end

    // Sequencer state and latched configuration registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_DEC;
            iaddr_q     <= '0;
            layerType_q <= '0;
            actType_q   <= '0;
            hasBias_q   <= 1'b0;
            cin_q       <= '0;
            cout_q      <= '0;
            baseAddr_q  <= '0;
            phase_q     <= '0;
            cfgIsD_q    <= 1'b0;
            err_q       <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            iaddr_q     <= iaddr_d;
            layerType_q <= layerType_d;
            actType_q   <= actType_d;
            hasBias_q   <= hasBias_d;
            cin_q       <= cin_d;
            cout_q      <= cout_d;
            baseAddr_q  <= baseAddr_d;
            phase_q     <= phase_d;
            cfgIsD_q    <= cfgIsD_d;
            err_q       <= err_d;
            halted_q    <= halted_d;
        end
    end

    // Loop stack push / pop / iteration-count decrement.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            loopSp_q <= '0;
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                loopStart_q[i] <= '0;
                loopRem_q[i]   <= '0;
            end
        end else if (pushEn) begin
            loopStart_q[pushIdx] <= iaddr_q + IADDR_W'(1);
            loopRem_q[pushIdx]   <= loopN;
            loopSp_q             <= loopSp_q + SP_W'(1);
        end else if (popEn) begin
            loopSp_q <= loopSp_q - SP_W'(1);
        end else if (decEn) begin
            loopRem_q[topIdx] <= loopRem_q[topIdx] - CNT_W'(1);
        end
    end

`ifdef INSN_SEQ_PERF_EN
    logic [31:0] perfCyc_q;

    // Count cycles spent in the engine handshake, saturating at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perfCyc_q <= '0;
        end else if (((state_q == S_START) || (state_q == S_WAIT)) && (perfCyc_q != '1)) begin
            perfCyc_q <= perfCyc_q + 32'd1;
        end
    end

    assign perf_cyc_o = perfCyc_q;
`else
    assign perf_cyc_o = '0;
`endif

    // Pulses come straight from the state register so an async reset removes them immediately.
    assign eng_start_o  = (state_q == S_START) ? engSel : '0;
    assign eng_rst_o    = ((state_q == S_CFG) && cfgIsD_q) ? engSel : '0;
    assign busy_o       = (state_q != S_DEC) || halted_q;
    assign iaddr_o      = iaddr_q;
    assign layer_type_o = layerType_q;
    assign act_type_o   = actType_q;
    assign has_bias_o   = hasBias_q;
    assign cin_o        = cin_q;
    assign cout_o       = cout_q;
    assign base_addr_o  = baseAddr_q;
    assign phase_o      = phase_q;
    assign halted_o     = halted_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_insn_sequencer.sv
// tb_insn_sequencer: directed programs for insn_sequencer with a scoreboard of
// expected engine start / reset pulses and an engine responder model.
`timescale 1ns/1ps

module tb_insn_sequencer;

   localparam logic [4:0] OP_CFGL = 5'h01;
   localparam logic [4:0] OP_CFGD = 5'h02;
   localparam logic [4:0] OP_LIF  = 5'h03;
   localparam logic [4:0] OP_LW   = 5'h04;
   localparam logic [4:0] OP_SOF  = 5'h05;
   localparam logic [4:0] OP_EOC  = 5'h06;
   localparam logic [4:0] OP_LOOP = 5'h07;
   localparam logic [4:0] OP_ENDL = 5'h08;
   localparam logic [4:0] OP_BAD  = 5'h1f;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        run_i;
   logic [12:0] iaddr_o;
   logic [31:0] idata_i;
   logic [4:0]  layer_type_o;
   logic [4:0]  act_type_o;
   logic        has_bias_o;
   logic [10:0] cin_o;
   logic [10:0] cout_o;
   logic [26:0] base_addr_o;
   logic [1:0]  phase_o;
   logic [1:0]  eng_rst_o;
   logic [1:0]  eng_start_o;
   logic [1:0]  eng_done_i;
   logic        busy_o;
   logic        halted_o;
   logic        err_o;
   logic [31:0] perf_cyc_o;

   typedef struct packed {
      logic [1:0]  eng;
      logic [1:0]  phase;
      logic [26:0] base;
      logic [12:0] iaddr;
   } startRec_t;

   typedef struct packed {
      logic [1:0]  eng;
      logic [10:0] cin;
      logic [10:0] cout;
   } rstRec_t;

   startRec_t   startQ[$];
   rstRec_t     rstQ[$];
   logic [31:0] rom [64];
   int          checks = 0;
   int          errors = 0;
   int          engLatency = 5;

   insn_sequencer dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i), .iaddr_o(iaddr_o), .idata_i(idata_i),
      .layer_type_o(layer_type_o), .act_type_o(act_type_o), .has_bias_o(has_bias_o),
      .cin_o(cin_o), .cout_o(cout_o), .base_addr_o(base_addr_o), .phase_o(phase_o),
      .eng_rst_o(eng_rst_o), .eng_start_o(eng_start_o), .eng_done_i(eng_done_i),
      .busy_o(busy_o), .halted_o(halted_o), .err_o(err_o), .perf_cyc_o(perf_cyc_o)
   );

   always #5 clk_i = ~clk_i;

   assign idata_i = rom[iaddr_o[5:0]];

   function automatic logic [31:0] mkCfgl(input logic [4:0] t, input logic [4:0] a, input logic b);
      return {OP_CFGL, 6'b0, t, 6'b0, a, 4'b0, b};
   endfunction

   function automatic logic [31:0] mkCfgd(input logic [10:0] ci, input logic [10:0] co);
      return {OP_CFGD, ci, co, 5'b0};
   endfunction

   function automatic logic [31:0] mkMem(input logic [4:0] op, input logic [26:0] base);
      return {op, base};
   endfunction

   function automatic logic [31:0] mkLoop(input logic [15:0] n);
      return {OP_LOOP, 11'b0, n};
   endfunction

   function automatic logic [31:0] mkOp(input logic [4:0] op);
      return {op, 27'b0};
   endfunction

   // Engine model: all done bits during the start cycle, foreign bits next cycle, real done after engLatency cycles.
   initial begin
      logic [1:0] sel;
      int lat;
      eng_done_i = '0;
      forever begin
         @(negedge clk_i);
         if (rst_ni && eng_start_o != '0) begin
            sel = eng_start_o;
            lat = engLatency;
            eng_done_i = '1;
            @(negedge clk_i);
            eng_done_i = ~sel;
            @(negedge clk_i);
            eng_done_i = '0;
            repeat (lat - 2) @(negedge clk_i);
            eng_done_i = sel;
            @(negedge clk_i);
            eng_done_i = '0;
         end
      end
   end

   // Monitor: every start or reset pulse seen must match the next queued expectation.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (eng_start_o != '0) begin
            startRec_t got, exp;
            got = {eng_start_o, phase_o, base_addr_o, iaddr_o};
            checks++;
            if (startQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL startPulse: got %h expected no start pulse", got);
            end else begin
               exp = startQ.pop_front();
               if (got !== exp) begin
                  errors++;
                  $display("[TB] FAIL startPulse: got %h expected %h", got, exp);
               end
            end
         end
         if (eng_rst_o != '0) begin
            rstRec_t got, exp;
            got = {eng_rst_o, cin_o, cout_o};
            checks++;
            if (rstQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL rstPulse: got %h expected no reset pulse", got);
            end else begin
               exp = rstQ.pop_front();
               if (got !== exp) begin
                  errors++;
                  $display("[TB] FAIL rstPulse: got %h expected %h", got, exp);
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clearRom();
      for (int i = 0; i < 64; i++) rom[i] = 32'h0;
   endtask

   task automatic applyStimulus();
      run_i  = 1'b0;
      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      run_i = 1'b1;
   endtask

   task automatic waitHalt(input string name, input int budget);
      int n = 0;
      while (!halted_o && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      checks++;
      if (!halted_o) begin
         errors++;
         $display("[TB] FAIL %s: got halted=0 expected halted=1 within %0d cycles", name, budget);
      end
   endtask

   task automatic waitStart(input string name, input int budget);
      int n = 0;
      while (eng_start_o == '0 && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      checks++;
      if (eng_start_o == '0) begin
         errors++;
         $display("[TB] FAIL %s: got no eng_start expected one within %0d cycles", name, budget);
      end
   endtask

   task automatic checkDrained(input string name);
      checkOutput({name, "PendingStart"}, 32'(startQ.size()), 32'd0);
      checkOutput({name, "PendingRst"}, 32'(rstQ.size()), 32'd0);
      startQ.delete();
      rstQ.delete();
   endtask

   task automatic checkError(input string name);
      waitHalt({name, "Halt"}, 200);
      checkOutput({name, "Err"}, 32'(err_o), 32'd1);
      checkOutput({name, "Busy"}, 32'(busy_o), 32'd1);
      checkDrained(name);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no completion expected $finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_ni = 1'b0;
      run_i  = 1'b0;

      // Config + single FC LIF with done five cycles after start
      clearRom();
      rom[0] = mkCfgl(5'd0, 5'd2, 1'b1);
      rom[1] = mkCfgd(11'd784, 11'd10);
      rom[2] = mkMem(OP_LIF, 27'h100);
      rom[3] = mkOp(OP_EOC);
      rstQ.push_back({2'b01, 11'd784, 11'd10});
      startQ.push_back({2'b01, 2'd0, 27'h100, 13'd3});
      engLatency = 5;
      repeat (3) @(negedge clk_i);
      checkOutput("rstIaddr", 32'(iaddr_o), 32'd0);
      checkOutput("rstBusy", 32'(busy_o), 32'd0);
      checkOutput("rstHalted", 32'(halted_o), 32'd0);
      checkOutput("rstErr", 32'(err_o), 32'd0);
      checkOutput("rstPulses", 32'({eng_start_o, eng_rst_o}), 32'd0);
      checkOutput("rstCfg", 32'({layer_type_o, act_type_o, has_bias_o, phase_o}), 32'd0);
      checkOutput("rstPerf", perf_cyc_o, 32'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      run_i = 1'b1;
      waitStart("lifStart", 50);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk_i);
         checkOutput("lifWaitBusy", 32'(busy_o), 32'd1);
      end
      @(negedge clk_i);
      checkOutput("lifDoneReturn", 32'(busy_o), 32'd0);
      waitHalt("lifHalt", 100);
      checkOutput("lifErr", 32'(err_o), 32'd0);
      checkOutput("lifIaddr", 32'(iaddr_o), 32'd4);
      checkOutput("cfgType", 32'(layer_type_o), 32'd0);
      checkOutput("cfgAct", 32'(act_type_o), 32'd2);
      checkOutput("cfgBias", 32'(has_bias_o), 32'd1);
      checkOutput("cfgCin", 32'(cin_o), 32'd784);
      checkOutput("cfgCout", 32'(cout_o), 32'd10);
`ifdef INSN_SEQ_PERF_EN
      checkOutput("perfCyc", perf_cyc_o, 32'd6);
`else
      checkOutput("perfCyc", perf_cyc_o, 32'd0);
`endif
      checkDrained("lif");

      // LOOP 3 around LW, then LOOP 0 (runs once) around SOF
      clearRom();
      rom[0] = mkCfgl(5'd1, 5'd0, 1'b0);
      rom[1] = mkLoop(16'd3);
      rom[2] = mkMem(OP_LW, 27'h20);
      rom[3] = mkOp(OP_ENDL);
      rom[4] = mkLoop(16'd0);
      rom[5] = mkMem(OP_SOF, 27'h7);
      rom[6] = mkOp(OP_ENDL);
      rom[7] = mkOp(OP_EOC);
      for (int k = 0; k < 3; k++) startQ.push_back({2'b10, 2'd1, 27'h20, 13'd3});
      startQ.push_back({2'b10, 2'd2, 27'h7, 13'd6});
      engLatency = 3;
      applyStimulus();
      waitHalt("loopHalt", 600);
      checkOutput("loopErr", 32'(err_o), 32'd0);
      checkOutput("loopIaddr", 32'(iaddr_o), 32'd8);
      checkDrained("loop");

      // Four nested LOOP 2 around one LIF: sixteen starts
      clearRom();
      rom[0] = mkCfgl(5'd0, 5'd1, 1'b0);
      for (int k = 1; k <= 4; k++) rom[k] = mkLoop(16'd2);
      rom[5] = mkMem(OP_LIF, 27'h40);
      for (int k = 6; k <= 9; k++) rom[k] = mkOp(OP_ENDL);
      rom[10] = mkOp(OP_EOC);
      for (int k = 0; k < 16; k++) startQ.push_back({2'b01, 2'd0, 27'h40, 13'd6});
      applyStimulus();
      waitHalt("nestHalt", 2000);
      checkOutput("nestErr", 32'(err_o), 32'd0);
      checkOutput("nestIaddr", 32'(iaddr_o), 32'd11);
      checkDrained("nest");

      // Five nested LOOPs overflow the stack
      clearRom();
      for (int k = 0; k < 5; k++) rom[k] = mkLoop(16'd1);
      rom[5] = mkOp(OP_EOC);
      applyStimulus();
      checkError("overflow");
      repeat (5) @(negedge clk_i);
      checkOutput("overflowStillHalted", 32'({halted_o, err_o}), 32'd3);

      // ENDL with empty stack
      clearRom();
      rom[0] = mkOp(OP_ENDL);
      rom[1] = mkOp(OP_EOC);
      applyStimulus();
      checkError("underflow");

      // Layer type beyond NUM_ENG, then LIF
      clearRom();
      rom[0] = mkCfgl(5'd7, 5'd0, 1'b0);
      rom[1] = mkMem(OP_LIF, 27'h55);
      rom[2] = mkOp(OP_EOC);
      applyStimulus();
      checkError("badEngLif");
      checkOutput("badEngType", 32'(layer_type_o), 32'd7);

      // Layer type beyond NUM_ENG, then CFGD
      clearRom();
      rom[0] = mkCfgl(5'd2, 5'd0, 1'b0);
      rom[1] = mkCfgd(11'd3, 11'd4);
      rom[2] = mkOp(OP_EOC);
      applyStimulus();
      checkError("badEngCfgd");

      // Unknown opcode
      clearRom();
      rom[0] = mkOp(OP_BAD);
      applyStimulus();
      checkError("badOpcode");

      // Async reset while waiting on an engine, run=0 stall, then clean restart
      clearRom();
      rom[0] = mkCfgl(5'd0, 5'd3, 1'b0);
      rom[1] = mkMem(OP_LIF, 27'h10);
      rom[2] = mkOp(OP_EOC);
      startQ.push_back({2'b01, 2'd0, 27'h10, 13'd2});
      engLatency = 20;
      applyStimulus();
      waitStart("midStart", 50);
      @(negedge clk_i);
      #2 rst_ni = 1'b0;
      run_i = 1'b0;
      #1;
      checkOutput("asyncBusy", 32'(busy_o), 32'd0);
      checkOutput("asyncIaddr", 32'(iaddr_o), 32'd0);
      checkOutput("asyncAct", 32'(act_type_o), 32'd0);
      checkOutput("asyncBase", 32'(base_addr_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (25) @(negedge clk_i);
      checkOutput("stallIaddr", 32'(iaddr_o), 32'd0);
      checkOutput("stallAct", 32'(act_type_o), 32'd0);
      checkOutput("stallBusy", 32'(busy_o), 32'd0);
      startQ.push_back({2'b01, 2'd0, 27'h10, 13'd2});
      engLatency = 5;
      run_i = 1'b1;
      waitHalt("restartHalt", 100);
      checkOutput("restartErr", 32'(err_o), 32'd0);
      checkOutput("restartAct", 32'(act_type_o), 32'd3);
      checkDrained("restart");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
